// File: rtl/seq_detect_compare.sv
// seq_detect_compare: Moore vs. Mealy sequence detector, side by side.
// A noisy pushbutton is synchronised and debounced into a one-cycle step
// enable. On each step, the serial bit A is shifted into a pattern history.
// A Mealy detect fires combinationally on the step cycle. A registered Moore
// detect follows one clock later and holds until the next step. Both detects
// feed saturating counters, so the one-clock Moore lag shows up on 'agree'.
//
// Handshake: there is no valid/ready pair here. step_pulse is the only
// qualifier. A is meaningful only on a cycle where step_pulse=1, and all
// detector state holds on every other cycle.
module seq_detect_compare #(
    parameter int                 PAT_LEN    = 4,
    parameter logic [PAT_LEN-1:0] PATTERN    = 4'b1011,
    parameter bit                 OVERLAP    = 1'b1,
    parameter int                 DEB_CYCLES = 500000,
    parameter int                 CNT_W      = 8
) (
    input  logic                         CLK,
    input  logic                         Reset,
    input  logic                         step_raw,
    input  logic                         A,
    output logic                         step_pulse,
    output logic                         z_mealy,
    output logic                         z_moore,
    output logic [$clog2(PAT_LEN+1)-1:0] fill,
    output logic [CNT_W-1:0]             cnt_mealy,
    output logic [CNT_W-1:0]             cnt_moore,
    output logic                         agree
);

    localparam int FW = $clog2(PAT_LEN + 1);
    localparam int DW = $clog2(DEB_CYCLES + 1);

    localparam logic [FW-1:0]    FILL_FULL = FW'(PAT_LEN);
    localparam logic [FW-1:0]    FILL_THR  = FW'(PAT_LEN - 1);
    localparam logic [DW-1:0]    DEB_LAST  = DW'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    // Synchroniser and debounce state
    logic          sync1_q, sync2_q;
    logic          stable_q, stable_d;
    logic          stable_dly_q;
    logic [DW-1:0] deb_cnt_q, deb_cnt_d;

    // Detector state. Only PAT_LEN-1 history bits are stored, because the
    // newest bit of every compared window is A itself.
    logic [PAT_LEN-2:0] hist_q, hist_d;
    logic [FW-1:0]      fill_q, fill_d;
    logic               z_moore_q, z_moore_d;
    logic               moore_pend_q, moore_pend_d;
    logic [CNT_W-1:0]   cnt_mealy_q, cnt_mealy_d;
    logic [CNT_W-1:0]   cnt_moore_q, cnt_moore_d;

    logic [PAT_LEN-1:0] window;
    logic               match;

    assign step_pulse = stable_q & ~stable_dly_q;
    assign window     = {hist_q, A};
    assign match      = (fill_q >= FILL_THR) && (window == PATTERN);
    assign z_mealy    = step_pulse & match;

    assign z_moore    = z_moore_q;
    assign fill       = fill_q;
    assign cnt_mealy  = cnt_mealy_q;
    assign cnt_moore  = cnt_moore_q;
    assign agree      = (cnt_mealy_q == cnt_moore_q);

    // Debounce: accept a new level only after it differs from the accepted level for DEB_CYCLES cycles in a row.
    always_comb begin
        stable_d  = stable_q;
        deb_cnt_d = '0;
        if (sync2_q != stable_q) begin
            if (deb_cnt_q == DEB_LAST) begin
                stable_d  = sync2_q;
                deb_cnt_d = '0;
            end else begin
                deb_cnt_d = deb_cnt_q + 1'b1;
            end
        end
    end

    // Detector: shift history, track fill and load the Moore output, only on a step.
    always_comb begin
        hist_d    = hist_q;
        fill_d    = fill_q;
        z_moore_d = z_moore_q;
        if (step_pulse) begin
            hist_d    = window[PAT_LEN-2:0];
            z_moore_d = match;
            if (match && (OVERLAP == 1'b0)) begin
                fill_d = '0;
            end else if (fill_q != FILL_FULL) begin
                fill_d = fill_q + 1'b1;
            end
        end
    end

    // Match counters: Mealy counts on the step cycle, Moore one cycle later; both saturate.
    always_comb begin
        moore_pend_d = z_mealy;
        cnt_mealy_d  = cnt_mealy_q;
        cnt_moore_d  = cnt_moore_q;
        if (z_mealy && (cnt_mealy_q != CNT_MAX)) begin
            cnt_mealy_d = cnt_mealy_q + 1'b1;
        end
        if (moore_pend_q && (cnt_moore_q != CNT_MAX)) begin
            cnt_moore_d = cnt_moore_q + 1'b1;
        end
    end

    // State registers with synchronous reset that overrides every update.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            stable_q     <= 1'b0;
            stable_dly_q <= 1'b0;
            deb_cnt_q    <= '0;
            hist_q       <= '0;
            fill_q       <= '0;
            z_moore_q    <= 1'b0;
            moore_pend_q <= 1'b0;
            cnt_mealy_q  <= '0;
            cnt_moore_q  <= '0;
        end else begin
            sync1_q      <= step_raw;
            sync2_q      <= sync1_q;
            stable_q     <= stable_d;
            stable_dly_q <= stable_q;
            deb_cnt_q    <= deb_cnt_d;
            hist_q       <= hist_d;
            fill_q       <= fill_d;
            z_moore_q    <= z_moore_d;
            moore_pend_q <= moore_pend_d;
            cnt_mealy_q  <= cnt_mealy_d;
            cnt_moore_q  <= cnt_moore_d;
        end
    end

endmodule

// File: tb/tb_seq_detect_compare.sv
// Bench for seq_detect_compare. Three instances share one button and data line:
// u_ov1 overlapping matches, u_ov0 history cleared on match, u_sat overlapping
// matches with 2-bit counters. A step-level model predicts every output each cycle.
module tb_seq_detect_compare;

    localparam int DEB     = 4;
    localparam int PAT_INT = 11;   // 4'b1011, oldest bit first

    logic CLK = 1'b0;
    logic Reset, step_raw, A;

    logic       sp0, sp1, sp2, zme0, zme1, zme2, zmo0, zmo1, zmo2, agr0, agr1, agr2;
    logic [2:0] fil0, fil1, fil2;
    logic [7:0] cme0, cme1, cmo0, cmo1;
    logic [1:0] cme2, cmo2;

    int n_checks = 0;
    int n_fail   = 0;
    int n_pulse  = 0;

    always #5 CLK = ~CLK;

    seq_detect_compare #(.PAT_LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .DEB_CYCLES(DEB), .CNT_W(8)) u_ov1 (
        .CLK(CLK), .Reset(Reset), .step_raw(step_raw), .A(A), .step_pulse(sp0), .z_mealy(zme0),
        .z_moore(zmo0), .fill(fil0), .cnt_mealy(cme0), .cnt_moore(cmo0), .agree(agr0));

    seq_detect_compare #(.PAT_LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b0), .DEB_CYCLES(DEB), .CNT_W(8)) u_ov0 (
        .CLK(CLK), .Reset(Reset), .step_raw(step_raw), .A(A), .step_pulse(sp1), .z_mealy(zme1),
        .z_moore(zmo1), .fill(fil1), .cnt_mealy(cme1), .cnt_moore(cmo1), .agree(agr1));

    seq_detect_compare #(.PAT_LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .DEB_CYCLES(DEB), .CNT_W(2)) u_sat (
        .CLK(CLK), .Reset(Reset), .step_raw(step_raw), .A(A), .step_pulse(sp2), .z_mealy(zme2),
        .z_moore(zmo2), .fill(fil2), .cnt_mealy(cme2), .cnt_moore(cmo2), .agree(agr2));

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_valid = 0;
    bit m_sync1, m_sync2, m_stable, m_step;
    int m_run;
    int hist_all[$];          // every bit accepted on a step since reset
    int start_idx[3];         // first history index still valid per instance
    int m_mealy[3], m_moore[3];
    bit m_pend[3], m_zmoore[3];

    function automatic int cmax(input int i);
        return (i == 2) ? 3 : 255;
    endfunction

    function automatic bit ovl(input int i);
        return (i != 1);
    endfunction

    function automatic bit model_match(input int i, input bit a);
        int n;
        int w;
        n = hist_all.size();
        if (n - start_idx[i] < 3) return 1'b0;
        w = hist_all[n-3] * 8 + hist_all[n-2] * 4 + hist_all[n-1] * 2 + int'(a);
        return (w == PAT_INT);
    endfunction

    function automatic int model_fill(input int i);
        int v;
        v = hist_all.size() - start_idx[i];
        return (v > 4) ? 4 : v;
    endfunction

    always @(posedge CLK) begin
        bit mt[3];
        bit old_st;
        bit s;
        if (Reset) begin
            m_valid = 1;
            m_sync1 = 0; m_sync2 = 0; m_stable = 0; m_step = 0; m_run = 0;
            hist_all.delete();
            for (int i = 0; i < 3; i++) begin
                start_idx[i] = 0; m_mealy[i] = 0; m_moore[i] = 0; m_pend[i] = 0; m_zmoore[i] = 0;
            end
        end else if (m_valid != 0) begin
            for (int i = 0; i < 3; i++) mt[i] = m_step ? model_match(i, A) : 1'b0;
            if (m_step) begin
                hist_all.push_back(int'(A));
                for (int i = 0; i < 3; i++)
                    if (mt[i] && !ovl(i)) start_idx[i] = hist_all.size();
            end
            for (int i = 0; i < 3; i++) begin
                if (m_pend[i] && m_moore[i] < cmax(i)) m_moore[i]++;
                if (mt[i] && m_mealy[i] < cmax(i)) m_mealy[i]++;
                if (m_step) m_zmoore[i] = mt[i];
                m_pend[i] = mt[i];
            end
            // A new button level is accepted after DEB consecutive differing samples.
            old_st  = m_stable;
            s       = m_sync2;
            m_sync2 = m_sync1;
            m_sync1 = step_raw;
            m_run   = (s != m_stable) ? m_run + 1 : 0;
            if (m_run == DEB) begin
                m_stable = s;
                m_run    = 0;
            end
            m_step = m_stable & ~old_st;
        end
    end

    // ---------------- per-cycle compare ----------------
    int g_sp[3], g_zme[3], g_zmo[3], g_fil[3], g_cme[3], g_cmo[3], g_agr[3];

    always @(negedge CLK) begin
        #1;
        if (m_valid != 0) begin
            g_sp  = '{int'(sp0), int'(sp1), int'(sp2)};
            g_zme = '{int'(zme0), int'(zme1), int'(zme2)};
            g_zmo = '{int'(zmo0), int'(zmo1), int'(zmo2)};
            g_fil = '{int'(fil0), int'(fil1), int'(fil2)};
            g_cme = '{int'(cme0), int'(cme1), int'(cme2)};
            g_cmo = '{int'(cmo0), int'(cmo1), int'(cmo2)};
            g_agr = '{int'(agr0), int'(agr1), int'(agr2)};
            for (int i = 0; i < 3; i++) begin
                check($sformatf("u%0d_step_pulse", i), g_sp[i], int'(m_step));
                check($sformatf("u%0d_z_mealy", i), g_zme[i], int'(m_step && model_match(i, A)));
                check($sformatf("u%0d_z_moore", i), g_zmo[i], int'(m_zmoore[i]));
                check($sformatf("u%0d_fill", i), g_fil[i], model_fill(i));
                check($sformatf("u%0d_cnt_mealy", i), g_cme[i], m_mealy[i]);
                check($sformatf("u%0d_cnt_moore", i), g_cmo[i], m_moore[i]);
                check($sformatf("u%0d_agree", i), g_agr[i], int'(m_mealy[i] == m_moore[i]));
            end
            if (sp0) n_pulse++;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_pulse(output int k);
        k = 0;
        while (k < 40) begin
            @(posedge CLK);
            @(negedge CLK);
            k++;
            if (sp0) break;
        end
    endtask

    task automatic press(input bit a, output bit z0, output bit z1, output bit z2, output bit mo0);
        int lat;
        step_raw = 1'b1;
        A        = a;
        wait_pulse(lat);
        check("press_latency", lat, 6);
        z0  = zme0;
        z1  = zme1;
        z2  = zme2;
        mo0 = zmo0;
    endtask

    task automatic release_btn();
        @(negedge CLK);
        step_raw = 1'b0;
        A        = ~A;
        repeat (12) @(negedge CLK);
    endtask

    // ---------------- directed sequence ----------------
    bit          seq [16] = '{1, 0, 1, 1, 0, 1, 1, 0, 1, 1, 0, 1, 1, 0, 1, 1};
    logic [15:0] exp_ov1  = 16'b1001_0010_0100_1000;   // bit s: match on step s+1
    logic [15:0] exp_ov0  = 16'b1000_0010_0000_1000;

    initial begin
        int  k;
        int  n0;
        bit  z0, z1, z2, mo0;
        Reset    = 1'b1;
        step_raw = 1'b0;
        A        = 1'b0;
        repeat (3) @(negedge CLK);
        check("rst_step_pulse", int'(sp0), 0);
        check("rst_z_mealy", int'(zme0), 0);
        check("rst_z_moore", int'(zmo0), 0);
        check("rst_fill", int'(fil0), 0);
        check("rst_cnt_mealy", int'(cme0), 0);
        check("rst_cnt_moore", int'(cmo0), 0);
        check("rst_agree", int'(agr0), 1);
        Reset = 1'b0;
        repeat (4) @(negedge CLK);

        // Bouncy press: toggle every 2 clocks for 20 clocks, then hold high.
        n0 = n_pulse;
        for (int j = 0; j < 10; j++) begin
            step_raw = (j % 2 == 0);
            repeat (2) @(negedge CLK);
        end
        check("bounce_no_pulse", n_pulse, n0);
        step_raw = 1'b1;
        wait_pulse(k);
        check("debounce_latency", k, 6);
        repeat (10) @(negedge CLK);
        check("one_pulse_per_press", n_pulse, n0 + 1);

        // Bouncy release: no pulse at all.
        n0 = n_pulse;
        for (int j = 0; j < 10; j++) begin
            step_raw = (j % 2 == 1);
            repeat (2) @(negedge CLK);
        end
        step_raw = 1'b0;
        repeat (12) @(negedge CLK);
        check("release_no_pulse", n_pulse, n0);

        Reset = 1'b1;
        @(negedge CLK);
        Reset = 1'b0;
        @(negedge CLK);

        // Detector sequence 1,0,1,1,0,1,1 and then three more 0,1,1 groups.
        for (int s = 0; s < 16; s++) begin
            press(seq[s], z0, z1, z2, mo0);
            check($sformatf("ov1_mealy_step%0d", s + 1), int'(z0), int'(exp_ov1[s]));
            check($sformatf("ov0_mealy_step%0d", s + 1), int'(z1), int'(exp_ov0[s]));
            check($sformatf("sat_mealy_step%0d", s + 1), int'(z2), int'(exp_ov1[s]));
            if (s == 3) begin
                @(negedge CLK);
                check("lag_cnt_mealy", int'(cme0), 1);
                check("lag_cnt_moore", int'(cmo0), 0);
                check("lag_agree", int'(agr0), 0);
                check("lag_z_moore", int'(zmo0), 1);
                @(negedge CLK);
                check("catchup_cnt_moore", int'(cmo0), 1);
                check("catchup_agree", int'(agr0), 1);
            end
            if (s == 4) begin
                check("moore_held_to_step5", int'(mo0), 1);
                @(negedge CLK);
                check("moore_clear_after_step5", int'(zmo0), 0);
            end
            release_btn();
            if (s == 6) begin
                check("ov1_cnt_mealy_7", int'(cme0), 2);
                check("ov1_cnt_moore_7", int'(cmo0), 2);
                check("ov1_agree_7", int'(agr0), 1);
                check("ov0_cnt_mealy_7", int'(cme1), 1);
                check("ov0_cnt_moore_7", int'(cmo1), 1);
            end
        end
        check("ov1_cnt_mealy_16", int'(cme0), 5);
        check("ov1_cnt_moore_16", int'(cmo0), 5);
        check("ov0_cnt_mealy_16", int'(cme1), 3);
        check("sat_cnt_mealy", int'(cme2), 3);
        check("sat_cnt_moore", int'(cmo2), 3);
        check("sat_agree", int'(agr2), 1);

        // Reset after steps 1,0,1, then 1,0,1,1.
        Reset = 1'b1;
        @(negedge CLK);
        Reset = 1'b0;
        @(negedge CLK);
        for (int s = 0; s < 3; s++) begin
            press(seq[s], z0, z1, z2, mo0);
            release_btn();
        end
        Reset = 1'b1;
        @(negedge CLK);
        Reset = 1'b0;
        press(1'b1, z0, z1, z2, mo0);
        check("post_rst_step1_no_match", int'(z0), 0);
        @(negedge CLK);
        check("post_rst_fill1", int'(fil0), 1);
        release_btn();
        press(1'b0, z0, z1, z2, mo0);
        check("post_rst_step2", int'(z0), 0);
        release_btn();
        press(1'b1, z0, z1, z2, mo0);
        check("post_rst_step3", int'(z0), 0);
        release_btn();
        press(1'b1, z0, z1, z2, mo0);
        check("post_rst_step4_ov1", int'(z0), 1);
        check("post_rst_step4_ov0", int'(z1), 1);
        release_btn();
        check("post_rst_fill_ov1", int'(fil0), 4);
        check("post_rst_fill_ov0", int'(fil1), 0);

        // Button held through a reset that lands mid-debounce.
        step_raw = 1'b1;
        A        = 1'b0;
        repeat (2) @(negedge CLK);
        Reset = 1'b1;
        @(negedge CLK);
        Reset = 1'b0;
        wait_pulse(k);
        check("held_through_reset_latency", k, 6);
        release_btn();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "bench did not complete");
    end

endmodule
